// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one op at a time over a word-wide valid/ready data port,
// with byte-lane steering for stores and alignment/extension for loads.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_we,
   output logic [3:0]            dmem_be,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  done_valid,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  fault,
   output logic                  stall
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t                  state_reg;
   logic                    req_ready_reg;
   logic                    dmem_req_valid_reg;
   logic                    dmem_we_reg;
   logic [3:0]              dmem_be_reg;
   logic [ADDR_WIDTH-1:0]   dmem_addr_reg;
   logic [DATA_WIDTH-1:0]   dmem_wdata_reg;
   logic                    done_valid_reg;
   logic [DATA_WIDTH-1:0]   load_data_reg;
   logic                    fault_reg;
   logic                    stall_reg;
   logic [2:0]              funct3_reg;
   logic [1:0]              off_reg;

   logic                    req_legal;
   logic [3:0]              store_be;
   logic [DATA_WIDTH-1:0]   store_wdata;
   logic [DATA_WIDTH-1:0]   rdata_shifted;
   logic [DATA_WIDTH-1:0]   load_next;

   function automatic logic is_legal(input logic st, input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      case (f3)
         3'd0:    ok = 1'b1;
         3'd1:    ok = ~off[0];
         3'd2:    ok = (off == 2'b00);
         3'd4:    ok = ~st;
         3'd5:    ok = ~st & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign req_legal = is_legal(req_is_store, req_funct3, req_addr[1:0]);

   always_comb begin
      case (req_funct3[1:0])
         2'b00:   store_be = 4'b0001 << req_addr[1:0];
         2'b01:   store_be = 4'b0011 << req_addr[1:0];
         default: store_be = 4'b1111;
      endcase
   end

   // Each lane carries the byte of rs2 that lands there: bytes replicate, halves repeat.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
         assign store_wdata[8*gi +: 8] =
            (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
            (req_funct3[1:0] == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                         req_wdata[8*gi +: 8];
      end
   endgenerate

   assign rdata_shifted = dmem_rdata >> {off_reg, 3'b000};

   always_comb begin
      case (funct3_reg)
         3'd0:    load_next = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'd4:    load_next = {24'd0, rdata_shifted[7:0]};
         3'd1:    load_next = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'd5:    load_next = {16'd0, rdata_shifted[15:0]};
         default: load_next = rdata_shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg          <= IDLE;
         req_ready_reg      <= 1'b1;
         dmem_req_valid_reg <= 1'b0;
         dmem_we_reg        <= 1'b0;
         dmem_be_reg        <= 4'd0;
         dmem_addr_reg      <= '0;
         dmem_wdata_reg     <= '0;
         done_valid_reg     <= 1'b0;
         load_data_reg      <= '0;
         fault_reg          <= 1'b0;
         stall_reg          <= 1'b0;
         funct3_reg         <= 3'd0;
         off_reg            <= 2'd0;
      end else begin
         done_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  funct3_reg    <= req_funct3;
                  off_reg       <= req_addr[1:0];
                  req_ready_reg <= 1'b0;
                  stall_reg     <= 1'b1;
                  load_data_reg <= '0;
                  if (req_legal) begin
                     state_reg          <= REQ;
                     fault_reg          <= 1'b0;
                     dmem_req_valid_reg <= 1'b1;
                     dmem_we_reg        <= req_is_store;
                     dmem_be_reg        <= req_is_store ? store_be : 4'b1111;
                     dmem_addr_reg      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     dmem_wdata_reg     <= req_is_store ? store_wdata : '0;
                  end else begin
                     state_reg      <= DONE;
                     fault_reg      <= 1'b1;
                     done_valid_reg <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid_reg <= 1'b0;
                  if (dmem_we_reg) begin
                     state_reg      <= DONE;
                     done_valid_reg <= 1'b1;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem_rsp_valid) begin
                  load_data_reg  <= load_next;
                  state_reg      <= DONE;
                  done_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
               stall_reg     <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req_ready      = req_ready_reg;
   assign dmem_req_valid = dmem_req_valid_reg;
   assign dmem_we        = dmem_we_reg;
   assign dmem_be        = dmem_be_reg;
   assign dmem_addr      = dmem_addr_reg;
   assign dmem_wdata     = dmem_wdata_reg;
   assign done_valid     = done_valid_reg;
   assign load_data      = load_data_reg;
   assign fault          = fault_reg;
   assign stall          = stall_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a memory responder checks request fields,
// a done monitor checks results and latency against an arithmetic reference model.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        done_valid;
   logic [31:0] load_data;
   logic        fault;
   logic        stall;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .done_valid(done_valid), .load_data(load_data), .fault(fault), .stall(stall)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rdy;
      int          rsp;
   } mem_t;

   typedef struct {
      logic        flt;
      logic [31:0] data;
      int          acc;
      int          lat;
   } done_t;

   mem_t  mem_q[$];
   done_t done_q[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int op_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
      int          size;
      logic [31:0] v;
      logic [31:0] mask;
      size = op_size(f3);
      v = rdata >> (8 * off);
      if (size < 4) begin
         mask = (32'd1 << (8 * size)) - 32'd1;
         v = v & mask;
         if (!f3[2] && v[8*size-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // Issue one op; called at a negedge and returns one negedge after the accept.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int rdy, input int rsp, input bit expect_done);
      int          n;
      int          size;
      logic        legal;
      mem_t        m;
      done_t       d;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
         return;
      end
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      size  = op_size(f3);
      legal = (st ? (f3 < 3'd3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
              && (addr % size == 0);
      d.acc = cyc;
      d.flt = !legal;
      d.data = (legal && !st) ? model_load(f3, addr[1:0], rdata) : 32'd0;
      d.lat = !legal ? 1 : st ? (2 + rdy) : (3 + rdy + rsp);
      if (legal) begin
         m.addr  = addr & 32'hFFFF_FFFC;
         m.we    = st;
         m.be    = st ? 4'(((1 << size) - 1) << addr[1:0]) : 4'hF;
         m.wdata = 32'd0;
         for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
         m.rdata = rdata;
         m.rdy   = rdy;
         m.rsp   = rsp;
         mem_q.push_back(m);
      end
      if (expect_done) done_q.push_back(d);
      $display("ISSUE st=%0d f3=%0d addr=%h wdata=%h rdata=%h rdy=%0d rsp=%0d legal=%0d",
               st, f3, addr, wdata, rdata, rdy, rsp, legal);
      @(negedge clk);
      req_valid    = 1'b0;
      req_funct3   = 3'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      chk("stall_after_accept", {31'd0, stall}, 32'd1);
   endtask

   // Memory responder: checks each request against the expected queue.
   initial begin
      mem_t m;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = 32'd0;
      forever begin
         @(negedge clk);
         dmem_rsp_valid = 1'b0;
         if (dmem_req_valid && !rst) begin
            if (mem_q.size() == 0) begin
               chk("unexpected_dmem_req", {31'd0, dmem_req_valid}, 32'd0);
               dmem_req_ready = 1'b1;
               @(negedge clk);
               dmem_req_ready = 1'b0;
            end else begin
               m = mem_q.pop_front();
               for (int k = 0; k <= m.rdy; k++) begin
                  if (k > 0) @(negedge clk);
                  chk("dmem_req_valid", {31'd0, dmem_req_valid}, 32'd1);
                  chk("dmem_addr", dmem_addr, m.addr);
                  chk("dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
                  chk("dmem_be", {28'd0, dmem_be}, {28'd0, m.be});
                  if (m.we) chk("dmem_wdata", dmem_wdata, m.wdata);
                  chk("stall_in_req", {31'd0, stall}, 32'd1);
               end
               dmem_req_ready = 1'b1;
               @(negedge clk);
               dmem_req_ready = 1'b0;
               chk("dmem_req_valid_drop", {31'd0, dmem_req_valid}, 32'd0);
               if (!m.we) begin
                  repeat (m.rsp) @(negedge clk);
                  dmem_rsp_valid = 1'b1;
                  dmem_rdata     = m.rdata;
                  @(negedge clk);
                  dmem_rsp_valid = 1'b0;
                  dmem_rdata     = $urandom;
               end
            end
         end else if ($urandom_range(0, 7) == 0) begin
            dmem_rsp_valid = 1'b1;
            dmem_rdata     = $urandom;
         end
      end
   end

   // Done monitor: pops the expected result whenever the unit reports completion.
   initial begin
      done_t d;
      forever begin
         @(negedge clk);
         if (done_valid) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", {31'd0, done_valid}, 32'd0);
            end else begin
               d = done_q.pop_front();
               chk("fault", {31'd0, fault}, {31'd0, d.flt});
               chk("load_data", load_data, d.data);
               chk("latency", cyc - d.acc, d.lat);
               chk("stall_at_done", {31'd0, stall}, 32'd1);
               $display("DONE fault=%0d load_data=%h latency=%0d", fault, load_data, cyc - d.acc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_is_store = 1'b0;
      req_funct3   = 3'd0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_dmem_req_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 1'b1);
      issue(1'b0, 3'd5, 32'h202, 32'h0, 32'h9ABC_5678, 0, 0, 1'b1);
      issue(1'b0, 3'd1, 32'h202, 32'h0, 32'h9ABC_5678, 0, 0, 1'b1);
      issue(1'b1, 3'd0, 32'h301, 32'h0000_00A5, 32'h0, 0, 0, 1'b1);
      issue(1'b1, 3'd2, 32'h402, 32'h1234_5678, 32'h0, 0, 0, 1'b1);
      issue(1'b0, 3'd2, 32'h500, 32'h0, 32'hDEAD_BEEF, 3, 2, 1'b1);
      issue(1'b0, 3'd3, 32'h600, 32'h0, 32'h1111_1111, 0, 0, 1'b1);

      for (int i = 0; i < 80; i++) begin
         st = 1'($urandom);
         f3 = 3'($urandom);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) | ($urandom_range(0, 1) << 2));
            if (f3 == 3'd6) f3 = 3'd4;
            a = a & ~32'(op_size(f3) - 1);
         end
         issue(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end

      n = 0;
      while ((done_q.size() != 0 || mem_q.size() != 0 || !req_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", done_q.size() + mem_q.size(), 32'd0);

      // Reset while waiting for read data; the late response must be ignored.
      issue(1'b0, 3'd2, 32'h700, 32'h0, 32'hCAFE_F00D, 0, 3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_load_data", load_data, 32'd0);
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      chk("midrst_dmem_req_valid", {31'd0, dmem_req_valid}, 32'd0);

      issue(1'b0, 3'd4, 32'h803, 32'h0, 32'h7F00_0000, 1, 1, 1'b1);
      n = 0;
      while (done_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("final_drain", done_q.size(), 32'd0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
